// File: rtl/sargantana_itag_lookup_ctrl.sv
// Instruction-cache tag lookup controller: compare, miss/refill, flush sequencing.
// Optional ICACHE_LFSR_REPL_EN selects LFSR replacement instead of round-robin.
module sargantana_itag_lookup_ctrl #(
    parameter int ICACHE_N_WAY   = 4,
    parameter int TAG_DEPTH      = 64,
    parameter int TAG_ADDR_WIDHT = $clog2(TAG_DEPTH),
    parameter int TAG_WIDHT      = 20
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic                                   lookup_valid_i,
    output logic                                   lookup_ready_o,
    input  logic [TAG_ADDR_WIDHT-1:0]              lookup_idx_i,
    input  logic [TAG_WIDHT-1:0]                   lookup_tag_i,
    input  logic                                   flush_i,
    output logic                                   resp_valid_o,
    output logic                                   resp_hit_o,
    output logic [ICACHE_N_WAY-1:0]                resp_way_o,
    output logic                                   refill_req_o,
    output logic [ICACHE_N_WAY-1:0]                refill_way_o,
    input  logic                                   refill_done_i,
    output logic [ICACHE_N_WAY-1:0]                tag_req_o,
    output logic                                   tag_we_o,
    output logic                                   tag_vbit_o,
    output logic                                   tag_flush_o,
    output logic [TAG_WIDHT-1:0]                   tag_data_o,
    output logic [TAG_ADDR_WIDHT-1:0]              tag_addr_o,
    input  logic [ICACHE_N_WAY-1:0][TAG_WIDHT-1:0] tag_way_i,
    input  logic [ICACHE_N_WAY-1:0]                vbit_i
);

    localparam int WAY_W = $clog2(ICACHE_N_WAY);

    typedef enum logic [2:0] {
        IDLE,
        CMP,
        MISS_WAIT,
        WRITE,
        FLUSH
    } state_t;

    state_t state_q, state_d;

    logic [TAG_ADDR_WIDHT-1:0] idx_q;
    logic [TAG_WIDHT-1:0]      tag_q;
    logic [ICACHE_N_WAY-1:0]   victim_q, victim_d;
    logic                      use_repl_q, use_repl_d;
    logic [ICACHE_N_WAY-1:0]   hit, hit_first;
    logic [ICACHE_N_WAY-1:0]   invalid, inv_first;
    logic [ICACHE_N_WAY-1:0]   repl_oh;
    logic [WAY_W-1:0]          repl_idx;
    logic                      accept;

    assign lookup_ready_o = !rst_i && (state_q == IDLE) && !flush_i;
    assign accept         = lookup_valid_i && lookup_ready_o;
    assign refill_way_o   = refill_req_o ? victim_q : '0;

`ifdef ICACHE_LFSR_REPL_EN
    logic [7:0] lfsr_q;

    // Free-running x^8+x^6+x^5+x^4+1 Fibonacci LFSR
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) lfsr_q <= 8'h01;
        else       lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    assign repl_idx = lfsr_q[WAY_W-1:0];
`else
    logic [WAY_W-1:0] rr_q;

    // Round-robin pointer advances only when it actually chose the victim
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                              rr_q <= '0;
        else if (state_q == WRITE && use_repl_q) rr_q <= rr_q + 1'b1;
    end

    assign repl_idx = rr_q;
`endif

    // Per-way tag compare and victim selection
    always_comb begin
        hit     = '0;
        repl_oh = '0;
        for (int w = 0; w < ICACHE_N_WAY; w++) begin
            hit[w] = vbit_i[w] && (tag_way_i[w] == tag_q);
        end
        repl_oh[repl_idx] = 1'b1;
        invalid    = ~vbit_i;
        hit_first  = hit & (~hit + ICACHE_N_WAY'(1));
        inv_first  = invalid & (~invalid + ICACHE_N_WAY'(1));
        use_repl_d = ~|invalid;
        victim_d   = use_repl_d ? repl_oh : inv_first;
    end

    // Next state and combinational tag-memory controls
    always_comb begin
        state_d     = state_q;
        tag_req_o   = '0;
        tag_we_o    = 1'b0;
        tag_vbit_o  = 1'b0;
        tag_flush_o = 1'b0;
        tag_data_o  = '0;
        tag_addr_o  = '0;
        if (!rst_i) begin
            unique case (state_q)
                IDLE: begin
                    if (flush_i) begin
                        state_d = FLUSH;
                    end else if (accept) begin
                        tag_req_o  = '1;
                        tag_addr_o = lookup_idx_i;
                        state_d    = CMP;
                    end
                end
                CMP: begin
                    if (flush_i)   state_d = FLUSH;
                    else if (|hit) state_d = IDLE;
                    else           state_d = MISS_WAIT;
                end
                MISS_WAIT: begin
                    if (flush_i)            state_d = FLUSH;
                    else if (refill_done_i) state_d = WRITE;
                end
                WRITE: begin
                    tag_req_o  = victim_q;
                    tag_we_o   = 1'b1;
                    tag_vbit_o = 1'b1;
                    tag_data_o = tag_q;
                    tag_addr_o = idx_q;
                    state_d    = flush_i ? FLUSH : IDLE;
                end
                FLUSH: begin
                    tag_flush_o = 1'b1;
                    state_d     = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State, request latch, registered response and refill request
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            tag_q        <= '0;
            victim_q     <= '0;
            use_repl_q   <= 1'b0;
            resp_valid_o <= 1'b0;
            resp_hit_o   <= 1'b0;
            resp_way_o   <= '0;
            refill_req_o <= 1'b0;
        end else begin
            state_q      <= state_d;
            resp_valid_o <= 1'b0;
            resp_hit_o   <= 1'b0;
            resp_way_o   <= '0;
            if (accept) begin
                idx_q <= lookup_idx_i;
                tag_q <= lookup_tag_i;
            end
            if (state_q == CMP && !flush_i) begin
                resp_valid_o <= 1'b1;
                resp_hit_o   <= |hit;
                resp_way_o   <= hit_first;
                if (!(|hit)) begin
                    victim_q     <= victim_d;
                    use_repl_q   <= use_repl_d;
                    refill_req_o <= 1'b1;
                end
            end
            if (state_q == MISS_WAIT && (flush_i || refill_done_i)) begin
                refill_req_o <= 1'b0;
            end
        end
    end

endmodule
